// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
package serial_adder_pkg;

    localparam int SA_N = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } sa_state_e;

    // Bit counter has to hold values up to N.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle of the bit-serial adder
// Signals: start, a, b, c_in (requester -> adder); busy, done, sum, c_out
// (adder -> requester); ovf only when SERIAL_ADDER_OVF_EN is defined.
interface serial_adder_if #(
    parameter int N = serial_adder_pkg::SA_N
);
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         c_in;
    logic         busy;
    logic         done;
    logic [N-1:0] sum;
    logic         c_out;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;

    modport master (output start, a, b, c_in, input busy, done, sum, c_out, ovf);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out, ovf);
`else
    modport master (output start, a, b, c_in, input busy, done, sum, c_out);
    modport slave  (input start, a, b, c_in, output busy, done, sum, c_out);
`endif
endinterface

// File: rtl/serial_adder_full_adder.sv
// rtl/serial_adder_full_adder.sv - one-bit combinational full-adder cell
// Ports: x, y, ci (addend bits and carry in); s (sum bit), co (carry out).
module full_adder (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);
endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - N-bit bit-serial adder, one full-adder slice per clock
// Ports: clk, rst_n (synchronous, active-low); bus (serial_adder_if.slave):
// start/a/b/c_in in, busy/done/sum/c_out out.
// Optional macro SERIAL_ADDER_OVF_EN adds bus.ovf (signed overflow flag).
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = SA_N
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_adder_if.slave  bus
);
    localparam int            CW   = cnt_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    sa_state_e     state;
    logic [N-1:0]  a_sr;
    logic [N-1:0]  b_sr;
    logic [N-1:0]  sum_q;
    logic          carry;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic          done_q;
    logic          c_out_q;
    logic          fa_s;
    logic          fa_co;
`ifdef SERIAL_ADDER_OVF_EN
    logic          ovf_q;
`endif

    full_adder u_fa (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            c_out_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                // DONE accepts a new start just like IDLE so operations can
                // run back to back without an idle cycle.
                IDLE, DONE: begin
                    if (bus.start) begin
                        a_sr   <= bus.a;
                        b_sr   <= bus.b;
                        carry  <= bus.c_in;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    sum_q <= {fa_s, sum_q[N-1:1]};
                    a_sr  <= a_sr >> 1;
                    b_sr  <= b_sr >> 1;
                    carry <= fa_co;
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        // carry still holds the carry into the MSB here.
                        c_out_q <= fa_co;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= carry ^ fa_co;
`endif
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state   <= DONE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.sum   = sum_q;
    assign bus.c_out = c_out_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule
